// File: rtl/dma_tx_pkg.sv
// Shared types and helpers for the graph-host DMA_TX channel pointer engine.
// Pointers, lengths and ring sizes are all in 64-byte units (26 bits).
package dma_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } dmat_state_e;

    localparam int ERR_RP_RANGE = 0;
    localparam int ERR_RP_ADV   = 1;
    localparam int ERR_DONE_LEN = 2;
    localparam int ERR_ZERO_LEN = 3;

    localparam logic [2:0] MODE_GH = 3'h1;

    // Segment alignment mask: mode 0 is 1KB (16 units), each step doubles.
    function automatic logic [25:0] aline_mask(input logic [2:0] mode);
        return (26'h10 << mode) - 26'd1;
    endfunction

    // (a - b) mod size, for a and b already inside [0, size).
    function automatic logic [25:0] ring_diff(input logic [25:0] a,
                                              input logic [25:0] b,
                                              input logic [25:0] size);
        return (a >= b) ? (a - b) : (a + size - b);
    endfunction

endpackage

// File: rtl/dma_tx_ring_ptr.sv
// One ring pointer register that advances by a length and wraps at the ring size.
module dma_tx_ring_ptr (
    input  logic        user_clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [25:0] add_len,
    input  logic [25:0] size,
    output logic [25:0] ptr
);

    logic [26:0] sum;
    logic [25:0] wrapped;

    assign sum     = {1'b0, ptr} + {1'b0, add_len};
    assign wrapped = sum[25:0] - size;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (add_en) begin
            ptr <= (sum >= {1'b0, size}) ? wrapped : sum[25:0];
        end
    end

endmodule

// File: rtl/dma_tx_ch_gh.sv
// Per-channel graph-host transmit pointer engine: splits frame requests into
// wrap/alignment-bounded descriptors and tracks the host ring pointers.
module dma_tx_ch_gh
    import dma_tx_pkg::*;
(
    input  logic         user_clk,
    input  logic         reset_n,
    input  logic [2:0]   chx_txch_mode,
    input  logic         chx_txch_enb,
    input  logic         chx_txch_clr_exec,
    input  logic [63:6]  chx_drbuf_addr,
    input  logic [31:6]  chx_drbuf_size,
    input  logic [2:0]   seg_aline_mode,
    input  logic         chx_tx_req_valid,
    output logic         chx_tx_req_ready,
    input  logic [31:6]  chx_tx_req_len,
    input  logic         chx_tx_req_last,
    input  logic         chx_drbuf_rp_update,
    input  logic [31:0]  d2d_rp,
    input  logic         chx_dscq_full,
    output logic         chx_dscq_we_gh,
    output logic [63:6]  chx_dsc_dst_addr_gh,
    output logic [31:6]  chx_dsc_dst_len_gh,
    output logic         chx_dsc_last_gh,
    input  logic         chx_dma_wt_done,
    input  logic [31:6]  chx_dma_wt_done_len,
    input  logic         chx_dma_wt_done_last,
    output logic         d2d_wp_update,
    output logic [31:0]  d2d_wp,
    output logic         d2d_frame_last,
    output logic [31:6]  chx_drbuf_wp,
    output logic [31:6]  chx_drbuf_wp_pros,
    output logic [31:6]  chx_drbuf_rp,
    output logic [31:6]  chx_drbuf_inflight,
    output logic         chx_dmat_busy,
    input  logic         reg_dma_tx_err_1wc,
    output logic [3:0]   chx_set_reg_dma_tx_err_gh
);

    dmat_state_e state;
    logic [25:0] size;
    logic [25:0] remaining;
    logic [25:0] seg;
    logic        req_last_q;
    logic        rst_done;
    logic [25:0] wp;
    logic [25:0] wp_pros;
    logic [25:0] rp;
    logic [25:0] inflight;
    logic [3:0]  err_q;
    logic        clr;
    logic        enb_ok;

    assign size   = chx_drbuf_size;
    assign clr    = chx_txch_clr_exec;
    assign enb_ok = chx_txch_enb && (chx_txch_mode == MODE_GH);

    // ---------------- segment sizing and flow control ----------------
    logic [25:0] used_pros;
    logic [26:0] free_units;
    logic [25:0] space_end;
    logic [25:0] align_room;
    logic [25:0] seg_calc;
    logic        accept;
    logic        issue_fire;

    assign used_pros  = ring_diff(wp_pros, rp, size);
    assign free_units = {1'b0, size} - {1'b0, used_pros} - 27'd1;
    assign space_end  = size - wp_pros;
    assign align_room = (~(chx_drbuf_addr[31:6] + wp_pros) & aline_mask(seg_aline_mode)) + 26'd1;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a value first, so no latch is inferred.
    always_comb begin
        seg_calc = remaining;
        if (space_end < seg_calc)
            seg_calc = space_end;
        if (align_room < seg_calc)
            seg_calc = align_room;
    end

    // rst_done keeps ready low while in reset even if enable is already high.
    assign chx_tx_req_ready = rst_done && (state == ST_IDLE) && enb_ok && !clr;
    assign accept           = chx_tx_req_valid && chx_tx_req_ready;
    assign issue_fire       = (state == ST_ISSUE) && enb_ok && !clr && !chx_dscq_full &&
                              (free_units >= {1'b0, seg});

    // ---------------- peer read pointer ----------------
    logic [25:0] rp_new;
    logic [25:0] used_cmt;
    logic [25:0] rp_adv;
    logic        rp_bad;
    logic        rp_adv_bad;

    assign rp_new     = d2d_rp[31:6];
    assign rp_bad     = (rp_new >= size) || (d2d_rp[5:0] != 6'h0);
    assign used_cmt   = ring_diff(wp, rp, size);
    assign rp_adv     = ring_diff(rp_new, rp, size);
    assign rp_adv_bad = rp_adv > used_cmt;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            rp <= '0;
        end else if (clr) begin
            rp <= '0;
        end else if (chx_drbuf_rp_update && !rp_bad && !rp_adv_bad) begin
            rp <= rp_new;
        end
    end

    // ---------------- inflight accounting ----------------
    logic [25:0] in_total;
    logic [25:0] in_after;
    logic        done_over;

    assign in_total  = inflight + (issue_fire ? seg : 26'd0);
    assign in_after  = in_total - chx_dma_wt_done_len;
    assign done_over = chx_dma_wt_done && (chx_dma_wt_done_len > in_total);

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (clr) begin
            inflight <= '0;
        end else if (done_over) begin
            inflight <= '0;
        end else if (chx_dma_wt_done) begin
            inflight <= in_after;
        end else if (issue_fire) begin
            inflight <= in_total;
        end
    end

    // ---------------- ring pointers ----------------
    dma_tx_ring_ptr u_wp (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .add_en   (chx_dma_wt_done),
        .add_len  (chx_dma_wt_done_len),
        .size     (size),
        .ptr      (wp)
    );

    dma_tx_ring_ptr u_wp_pros (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .add_en   (issue_fire),
        .add_len  (seg),
        .size     (size),
        .ptr      (wp_pros)
    );

    // ---------------- request FSM with registered descriptor outputs ----------------
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            remaining           <= '0;
            seg                 <= '0;
            req_last_q          <= 1'b0;
            chx_dscq_we_gh      <= 1'b0;
            chx_dsc_dst_addr_gh <= '0;
            chx_dsc_dst_len_gh  <= '0;
            chx_dsc_last_gh     <= 1'b0;
        end else begin
            chx_dscq_we_gh <= 1'b0;
            if (clr) begin
                state     <= ST_IDLE;
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A zero-length request is consumed and dropped here.
                        if (accept && (chx_tx_req_len != 26'd0)) begin
                            remaining  <= chx_tx_req_len;
                            req_last_q <= chx_tx_req_last;
                            state      <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        seg   <= seg_calc;
                        state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (issue_fire) begin
                            chx_dscq_we_gh      <= 1'b1;
                            chx_dsc_dst_addr_gh <= chx_drbuf_addr + {32'd0, wp_pros};
                            chx_dsc_dst_len_gh  <= seg;
                            chx_dsc_last_gh     <= req_last_q && (remaining == seg);
                            remaining           <= remaining - seg;
                            state               <= (remaining != seg) ? ST_CALC : ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n)
            rst_done <= 1'b0;
        else
            rst_done <= 1'b1;
    end

    // ---------------- write-pointer publish ----------------
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            d2d_wp_update  <= 1'b0;
            d2d_frame_last <= 1'b0;
        end else begin
            d2d_wp_update  <= chx_dma_wt_done && !clr;
            d2d_frame_last <= chx_dma_wt_done && !clr && chx_dma_wt_done_last;
        end
    end

    // wp already holds the post-completion value in the publish cycle.
    assign d2d_wp = {wp, 6'h0};

    // ---------------- sticky errors ----------------
    logic [3:0] err_set;

    assign err_set[ERR_RP_RANGE] = chx_drbuf_rp_update && rp_bad && !clr;
    assign err_set[ERR_RP_ADV]   = chx_drbuf_rp_update && !rp_bad && rp_adv_bad && !clr;
    assign err_set[ERR_DONE_LEN] = done_over && !clr;
    assign err_set[ERR_ZERO_LEN] = accept && (chx_tx_req_len == 26'd0);

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= '0;
        else
            err_q <= (err_q & ~{4{reg_dma_tx_err_1wc}}) | (~err_q & err_set);
    end

    // ---------------- status ----------------
    assign chx_set_reg_dma_tx_err_gh = err_q;
    assign chx_drbuf_wp              = wp;
    assign chx_drbuf_wp_pros         = wp_pros;
    assign chx_drbuf_rp              = rp;
    assign chx_drbuf_inflight        = inflight;
    assign chx_dmat_busy             = (state != ST_IDLE) || (inflight != 26'd0);

endmodule
